// File: rtl/hilo_muldiv_unit_pkg.sv
// muldiv_pkg: opcode constants, FSM state encoding and opcode class helpers
package muldiv_pkg;
  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MTHI  = 4'd1;
  localparam logic [3:0] OP_MTLO  = 4'd2;
  localparam logic [3:0] OP_MULT  = 4'd3;
  localparam logic [3:0] OP_MULTU = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_DIV   = 4'd9;
  localparam logic [3:0] OP_DIVU  = 4'd10;
  typedef enum logic [2:0] {ST_IDLE, ST_SCAN, ST_MUL, ST_DIV, ST_FIX} state_e;
  function automatic logic is_mul(input logic [3:0] op);
    return op >= OP_MULT && op <= OP_MSUBU;
  endfunction
  function automatic logic is_div(input logic [3:0] op);
    return op == OP_DIV || op == OP_DIVU;
  endfunction
  function automatic logic mul_signed(input logic [3:0] op);
    return op == OP_MULT || op == OP_MADD || op == OP_MSUB;
  endfunction
endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if: bundle issue, flush and HI/LO result signals of the unit
interface hilo_muldiv_unit_if #(
  parameter int XLEN  = 32,
  parameter int LANES = 2
);
  logic                    flush_i;
  logic                    bundle_valid_i;
  logic                    bundle_ready_o;
  logic [LANES*4-1:0]      op_i;
  logic [LANES*XLEN-1:0]   rs_i;
  logic [LANES*XLEN-1:0]   rt_i;
  logic [XLEN-1:0]         hi_o;
  logic [XLEN-1:0]         lo_o;
  logic                    done_o;
  modport master (
    output flush_i, bundle_valid_i, op_i, rs_i, rt_i,
    input  bundle_ready_o, hi_o, lo_o, done_o
  );
  modport slave (
    input  flush_i, bundle_valid_i, op_i, rs_i, rt_i,
    output bundle_ready_o, hi_o, lo_o, done_o
  );
endinterface

// File: rtl/hilo_muldiv_unit_div_radix2.sv
// div_radix2: unsigned radix-2 restoring divider, one quotient bit per cycle
module div_radix2 #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cancel_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            valid_o
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q, valid_q;
  logic [XLEN:0]   shl, diff;
  // A zero divisor never borrows, so the quotient fills with ones and the remainder ends as the dividend
  assign shl  = {rem_q, quo_q[XLEN-1]};
  assign diff = shl - {1'b0, dvs_q};
  // Shift-subtract iteration; cancel outranks start so a flush never leaves a stale divide running
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (cancel_i) begin
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (start_i) begin
      rem_q   <= '0;
      quo_q   <= dividend_i;
      dvs_q   <= divisor_i;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      valid_q <= 1'b0;
    end else if (busy_q) begin
      rem_q   <= diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];
      quo_q   <= {quo_q[XLEN-2:0], ~diff[XLEN]};
      cnt_q   <= cnt_q + 1'b1;
      busy_q  <= cnt_q != LAST;
      valid_q <= cnt_q == LAST;
    end
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign valid_o     = valid_q;
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: retires a bundle of HI/LO lanes in order with a pipelined multiplier and iterative divider
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int LANES   = 2,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  hilo_muldiv_unit_if.slave bus
);
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int CW = $clog2(XLEN + MUL_LAT) + 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [CW-1:0] MUL_LAST  = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(XLEN - 1);
  state_e            state_q, state_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d;
  logic              adv, div_start, accept;
  logic [3:0]        op_q [LANES];
  logic [XLEN-1:0]   rs_q [LANES];
  logic [XLEN-1:0]   rt_q [LANES];
  logic [2*XLEN-1:0] mul_q [MUL_LAT];
  logic [3:0]        op_c;
  logic [XLEN-1:0]   rs_c, rt_c, rs_mag, rt_mag, quo, rem, q_fix, r_fix;
  logic [2*XLEN-1:0] a_ext, b_ext, prod, acc, mres;
  logic              sm, sd, rs_neg, rt_neg, div_valid;
  assign accept = bus.bundle_valid_i && state_q == ST_IDLE && !bus.flush_i;
  assign op_c   = op_q[lane_q];
  assign rs_c   = rs_q[lane_q];
  assign rt_c   = rt_q[lane_q];
  assign sm     = mul_signed(op_c);
  assign a_ext  = {{XLEN{sm & rs_c[XLEN-1]}}, rs_c};
  assign b_ext  = {{XLEN{sm & rt_c[XLEN-1]}}, rt_c};
  assign prod   = a_ext * b_ext;
  assign acc    = {hi_q, lo_q};
  assign mres   = (op_c == OP_MADD || op_c == OP_MADDU) ? acc + mul_q[MUL_LAT-1] :
                  (op_c == OP_MSUB || op_c == OP_MSUBU) ? acc - mul_q[MUL_LAT-1] : mul_q[MUL_LAT-1];
  assign sd     = op_c == OP_DIV;
  assign rs_neg = sd & rs_c[XLEN-1];
  assign rt_neg = sd & rt_c[XLEN-1];
  assign rs_mag = rs_neg ? -rs_c : rs_c;
  assign rt_mag = rt_neg ? -rt_c : rt_c;
  assign q_fix  = (rs_neg ^ rt_neg) ? -quo : quo;
  assign r_fix  = rs_neg ? -rem : rem;
  div_radix2 #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .rst        (rst),
    .cancel_i   (bus.flush_i),
    .start_i    (div_start),
    .dividend_i (rs_mag),
    .divisor_i  (rt_mag),
    .quotient_o (quo),
    .remainder_o(rem),
    .valid_o    (div_valid)
  );
  // Next state and HI/LO commit; flush overrides everything, including a commit due on the same edge
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    adv       = 1'b0;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.bundle_valid_i) begin
        state_d = ST_SCAN;
        lane_d  = '0;
      end
      ST_SCAN: if (is_mul(op_c)) begin
        state_d = ST_MUL;
        cnt_d   = '0;
      end else if (is_div(op_c)) begin
        state_d   = ST_DIV;
        cnt_d     = '0;
        div_start = 1'b1;
      end else begin
        hi_d = op_c == OP_MTHI ? rs_c : hi_q;
        lo_d = op_c == OP_MTLO ? rs_c : lo_q;
        adv  = 1'b1;
      end
      ST_MUL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == MUL_LAST) begin
          {hi_d, lo_d} = mres;
          adv          = 1'b1;
        end
      end
      ST_DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_LAST) state_d = ST_FIX;
      end
      ST_FIX: if (div_valid) begin
        hi_d = r_fix;
        lo_d = q_fix;
        adv  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (adv) begin
      state_d = lane_q == LAST_LANE ? ST_IDLE : ST_SCAN;
      lane_d  = lane_q == LAST_LANE ? '0 : lane_q + 1'b1;
      done_d  = lane_q == LAST_LANE;
    end
    if (bus.flush_i) begin
      state_d   = ST_IDLE;
      lane_d    = '0;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      div_start = 1'b0;
    end
  end
  // Control state and architectural HI/LO registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  // Bundle capture so the execute stage may change its lane inputs after accept
  always_ff @(posedge clk)
    if (accept)
      for (int k = 0; k < LANES; k++) begin
        op_q[k] <= bus.op_i[4*k +: 4];
        rs_q[k] <= bus.rs_i[XLEN*k +: XLEN];
        rt_q[k] <= bus.rt_i[XLEN*k +: XLEN];
      end
  // Free-running product chain; operands are stable for the whole MUL phase so the tail holds the lane's product
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < MUL_LAT; i++) mul_q[i] <= '0;
    end else begin
      mul_q[0] <= prod;
      for (int i = 1; i < MUL_LAT; i++) mul_q[i] <= mul_q[i-1];
    end
  assign bus.bundle_ready_o = state_q == ST_IDLE;
  assign bus.hi_o           = hi_q;
  assign bus.lo_o           = lo_q;
  assign bus.done_o         = done_q;
endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Parametrised multi-lane HI/LO execution unit: accepts a bundle of up to LANES multiply, divide, multiply-accumulate and HI/LO-move operations and owns the architectural HI/LO registers. It retires the lanes strictly in ascending lane order (lane 0 oldest), so the youngest writer always wins. It sits beside the execute stage, which holds the bundle until `bundle_ready_o` returns. It replaces the per-lane HI/LO merge and the external divider handshake with one sequential unit that has a pipelined multiplier and an iterative divider.

## Interface
- XLEN, 32, operand and HI/LO width.
- LANES, 2, number of issue lanes per bundle, minimum 1.
- MUL_LAT, 2, multiplier pipeline depth in cycles, minimum 1.

- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush_i  in  1  discard the current and any not-yet-accepted bundle.
- bundle_valid_i  in  1  bundle present on the lane inputs.
- bundle_ready_o  out  1  high in IDLE; a bundle is accepted on an edge where valid and ready are both high.
- op_i  in  LANES*4  per-lane opcode; lane k is bits [4k+3:4k].
- rs_i  in  LANES*XLEN  per-lane first operand.
- rt_i  in  LANES*XLEN  per-lane second operand.
- hi_o  out  XLEN  architectural HI.
- lo_o  out  XLEN  architectural LO.
- done_o  out  1  one-cycle pulse after the last lane of an accepted bundle commits.

## Operation
- Opcodes: NOP, MTHI, MTLO, MULT, MULTU, MADD, MADDU, MSUB, MSUBU, DIV, DIVU. Unused encodings behave as NOP.
- Accept latches all lanes into internal registers, so inputs may change afterwards. The lane index is cleared to 0.
- State machine:
  - IDLE -> SCAN on accept.
  - SCAN evaluates lane k:
    - NOP: no write.
    - MTHI: HI<=rs. MTLO: LO<=rs. The HI/LO write occurs at the end of SCAN.
    - MULT-class: -> MUL.
    - DIV-class: -> DIV.
    - In all cases, if k=LANES-1 the next state is IDLE and done_o fires next cycle; otherwise the next state is SCAN with k+1.
  - MUL: count MUL_LAT cycles. On the last cycle commit {HI,LO}, then proceed as for the end of a SCAN lane.
  - DIV: XLEN radix-2 restoring iterations on magnitudes, one per cycle, then -> FIX.
  - FIX: sign fix-up and commit, then proceed as for the end of a SCAN lane.
- Arithmetic:
  - MULT is signed XLEN x XLEN -> 2*XLEN; MULTU is unsigned.
  - MADD(U): {HI,LO} += product. MSUB(U): {HI,LO} -= product. The accumulation wraps modulo 2^(2*XLEN).
  - DIV(U): LO = quotient, HI = remainder.
  - Signed divide fix-up: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
  - Divide by zero: the unsigned core yields quotient all-ones and remainder |rs|, then fix-up applies.
  - Overflow case: 0x80000000 / 0xFFFFFFFF (signed) yields LO=0x80000000, HI=0.
- Operand dependency: a lane's MADD/MSUB reads the HI/LO as already updated by older lanes of the same bundle.
- Flush:
  - flush_i high on an edge forces IDLE and clears the lane index. A bundle valid on that edge is not accepted.
  - Lanes already committed keep their HI/LO writes; uncommitted lanes are dropped. No done_o is issued for the flushed bundle.
- Reset: state IDLE, hi_o=0, lo_o=0, bundle_ready_o=1, done_o=0. The divider and multiplier pipelines are cleared.

## Timing
- Accept occurs at edge 0; SCAN of lane 0 is cycle 1.
- Per-lane cost: 1 cycle for NOP/MTHI/MTLO, 1+MUL_LAT for MULT-class, 1+XLEN+1 for DIV-class.
- done_o and bundle_ready_o both go high in the cycle after the final commit edge. A new bundle can be accepted on that cycle's closing edge.
- hi_o and lo_o are registered outputs and change only on commit edges.
- flush_i takes priority over every other event on the same edge, including a commit scheduled for that edge.

## Structure
- Shared package `muldiv_pkg`: the 4-bit opcode constants and the state encoding (IDLE, SCAN, MUL, DIV, FIX).
- Sub-module `div_radix2`:
  - Inputs: start, dividend and divisor magnitudes.
  - Outputs: quotient, remainder, valid after XLEN cycles.
  - Supports a synchronous cancel driven by flush_i.
- The multiplier is inline: a MUL_LAT-deep register chain carrying the product.

## Test plan
- Reset mid-DIV (rst low at cycle 10 of DIV): hi_o=lo_o=0, bundle_ready_o=1 immediately; a fresh MTHI 0x5 bundle then gives hi_o=5.
- LANES=2, lane0 MTHI 0x11, lane1 MTHI 0x22: hi_o=0x22 after edge 2, done_o high in cycle 3.
- MULT rs=0xFFFFFFFE, rt=3, MUL_LAT=2: HI=0xFFFFFFFF, LO=0xFFFFFFFA committed at end of cycle 3, done_o in cycle 5.
- Lane0 MULTU 0x10000 x 0x10000, lane1 MADDU 0xFFFFFFFF x 1: HI=1, LO=0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 (-7/2): LO=0xFFFFFFFD, HI=0xFFFFFFFF, done_o in cycle 36. DIVU 7/0: LO=0xFFFFFFFF, HI=7.
- Lane0 MTLO 0x9, lane1 DIV; flush_i pulsed in cycle 5: lo_o stays 0x9, no done_o, bundle_ready_o=1 in cycle 6.
